// File: rtl/mdiv_engine_param_pkg.sv
// ---------------------------------------------------------------------------
// mdiv_pkg
// Shared definitions for the modular inversion/division engine:
//   - FSM state encoding (3-bit)
//   - operation mode constants (inverse / division)
//   - watchdog iteration limit helper (4*W steps)
// ---------------------------------------------------------------------------
package mdiv_pkg;

    // Engine FSM states. The values are visible on state_o for debug.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        HALVE_U = 3'd2,
        HALVE_V = 3'd3,
        SUB     = 3'd4,
        FIX     = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam logic MODE_INV = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // A correct binary extended Euclid run on W-bit operands needs at most
    // about 2*W halvings plus as many subtractions, so 4*W HALVE/SUB cycles
    // can only be exceeded by out-of-contract operands.
    function automatic int wdogLimit(input int w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/mdiv_engine_param_if.sv
// ---------------------------------------------------------------------------
// mdiv_engine_param_if
// Request/response bundle of the modular inversion/division engine.
//   start   : request, accepted only while ready=1
//   mode    : 0 = inverse (b forced to 1), 1 = division
//   a_in    : operand to invert / divisor, 0 < a_in < p_in
//   b_in    : dividend (division mode), < p_in
//   p_in    : odd modulus
//   ready   : engine idle
//   busy    : operation in progress (inverse of ready)
//   done    : one-cycle completion pulse (success or error)
//   err     : error flag, valid with done, held until next accept
//   result  : b * a^-1 mod p, 0 on error, held until next accept
//   state_o : current FSM state (debug)
// master modport = requester, slave modport = engine.
// ---------------------------------------------------------------------------
interface mdiv_engine_param_if #(
    parameter int W = 256
);
    import mdiv_pkg::*;

    logic         start;
    logic         mode;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] p_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;
    logic [2:0]   state_o;

    modport master (
        output start, mode, a_in, b_in, p_in,
        input  ready, busy, done, err, result, state_o
    );

    modport slave (
        input  start, mode, a_in, b_in, p_in,
        output ready, busy, done, err, result, state_o
    );

endinterface

// File: rtl/mdiv_engine_param_halve.sv
// ---------------------------------------------------------------------------
// mdiv_halve_mod
// Combinational modular halving: o_y = i_x / 2 mod i_p for odd i_p.
//   i_x : value in [0, p)
//   i_p : odd modulus
//   o_y : x>>1 when x is even, (x+p)>>1 when x is odd
// ---------------------------------------------------------------------------
module mdiv_halve_mod #(
    parameter int W = 256
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_p,
    output logic [W-1:0] o_y
);

    // The sum is kept one bit wider so the carry of x+p survives the shift.
    logic [W:0] w_sum;
    logic       w_unusedLsb;

    assign w_sum       = {1'b0, i_x} + {1'b0, i_p};
    assign w_unusedLsb = w_sum[0];
    assign o_y         = i_x[0] ? w_sum[W:1] : (i_x >> 1);

endmodule

// File: rtl/mdiv_engine_param.sv
// ---------------------------------------------------------------------------
// mdiv_engine_param
// Parametrised modular inversion/division engine computing
// result = b * a^-1 mod p (p odd) with the binary extended Euclidean
// algorithm, one algorithm step per clock.
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : mdiv_engine_param_if.slave (start/mode/a_in/b_in/p_in in,
//         ready/busy/done/err/result/state_o out)
// Parameters:
//   W     : operand / modulus width
//   CNT_W : watchdog counter width
// Configuration macro MDIV_WDOG_EN: when defined, a HALVE/SUB step counter
// forces an error after 4*W steps so out-of-contract operands cannot run
// indefinitely. When undefined there is no counter.
// ---------------------------------------------------------------------------
module mdiv_engine_param
    import mdiv_pkg::*;
#(
    parameter int W     = 256,
    parameter int CNT_W = $clog2(4*W) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    mdiv_engine_param_if.slave        bus
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic         r_ready;
    logic         r_done;
    logic         r_err;
    logic [W-1:0] r_result;
    logic [W-1:0] r_u;
    logic [W-1:0] r_v;
    logic [W-1:0] r_x1;
    logic [W-1:0] r_x2;
    logic [W-1:0] r_p;
    logic [W:0]   r_t;
    logic         r_sel;

    logic [W-1:0] w_x1Half;
    logic [W-1:0] w_x2Half;
    logic         w_uGeV;
    logic [W-1:0] w_uvDiff;
    logic [W:0]   w_xDiff;
    logic [W-1:0] w_fixSum;
    logic [W-1:0] w_fix;
    logic         w_wdogTrip;

    // Invariants x1*a == u*b and x2*a == v*b (mod p) are kept by halving
    // u/v together with x1/x2, so each x register needs its own halver.
    mdiv_halve_mod #(.W(W)) u_halveX1 (.i_x(r_x1), .i_p(r_p), .o_y(w_x1Half));
    mdiv_halve_mod #(.W(W)) u_halveX2 (.i_x(r_x2), .i_p(r_p), .o_y(w_x2Half));

    // One subtractor pair serves both SUB directions: the larger of u/v
    // minus the smaller, and the matching x difference kept W+1 bits wide
    // so its sign tells FIX whether p must be added back.
    assign w_uGeV   = (r_u >= r_v);
    assign w_uvDiff = w_uGeV ? (r_u - r_v) : (r_v - r_u);
    assign w_xDiff  = w_uGeV ? ({1'b0, r_x1} - {1'b0, r_x2})
                             : ({1'b0, r_x2} - {1'b0, r_x1});
    assign w_fixSum = r_t[W-1:0] + r_p;
    assign w_fix    = r_t[W] ? w_fixSum : r_t[W-1:0];

`ifdef MDIV_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(wdogLimit(W) - 1);

    logic [CNT_W-1:0] r_cnt;

    // Step counter: restarts on every accepted request and advances on each
    // HALVE/SUB cycle; the trip fires on the step that would reach 4*W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_cnt <= '0;
        end else if (r_state == HALVE_U || r_state == HALVE_V || r_state == SUB) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_wdogTrip = (r_cnt == WDOG_LAST);
`else
    logic w_unusedCnt;

    assign w_wdogTrip  = 1'b0;
    assign w_unusedCnt = |CNT_W;
`endif

    // Next algorithm step given the u/v values that will hold after the
    // current cycle; the priority order decides which x carries the answer.
    function automatic state_t route(input logic [W-1:0] u, input logic [W-1:0] v);
        if (u == '0 || v == '0) return ERR;
        else if (u == ONE)      return DONE;
        else if (v == ONE)      return DONE;
        else if (!u[0])         return HALVE_U;
        else if (!v[0])         return HALVE_V;
        else                    return SUB;
    endfunction

    // Main FSM with registered handshake outputs. done is a single-cycle
    // pulse issued together with ready on the return to IDLE, so a new
    // request may be presented in the very cycle done is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_p      <= '0;
            r_t      <= '0;
            r_sel    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_u     <= bus.a_in;
                        r_v     <= bus.p_in;
                        r_x1    <= (bus.mode == MODE_DIV) ? bus.b_in : ONE;
                        r_x2    <= '0;
                        r_p     <= bus.p_in;
                        r_err   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!r_p[0] || r_u == '0) r_state <= ERR;
                    else                      r_state <= route(r_u, r_v);
                end
                HALVE_U: begin
                    r_u  <= r_u >> 1;
                    r_x1 <= w_x1Half;
                    if (w_wdogTrip) r_state <= ERR;
                    else            r_state <= route(r_u >> 1, r_v);
                end
                HALVE_V: begin
                    r_v  <= r_v >> 1;
                    r_x2 <= w_x2Half;
                    if (w_wdogTrip) r_state <= ERR;
                    else            r_state <= route(r_u, r_v >> 1);
                end
                SUB: begin
                    if (w_uGeV) r_u <= w_uvDiff;
                    else        r_v <= w_uvDiff;
                    r_t   <= w_xDiff;
                    r_sel <= w_uGeV;
                    if (w_wdogTrip) r_state <= ERR;
                    else            r_state <= FIX;
                end
                FIX: begin
                    if (r_sel) r_x1 <= w_fix;
                    else       r_x2 <= w_fix;
                    r_state <= route(r_u, r_v);
                end
                DONE: begin
                    // Same priority as route(): u==1 means x1 holds b/a.
                    r_result <= (r_u == ONE) ? r_x1 : r_x2;
                    r_done   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
                ERR: begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                    r_done   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = ~r_ready;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.result  = r_result;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_mdiv_engine_param.sv
// ---------------------------------------------------------------------------
// tb_mdiv_engine_param
// Self-checking bench for mdiv_engine_param at W=64. Expected results come
// from a division-based extended Euclid reference model on wide signed
// integers. Honours MDIV_WDOG_EN for the out-of-contract operand test.
// ---------------------------------------------------------------------------
module tb_mdiv_engine_param;
    import mdiv_pkg::*;

    localparam int W      = 64;
    localparam int MAXCYC = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mdiv_engine_param_if #(.W(W)) bus ();

    mdiv_engine_param #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: b * a^-1 mod p via classic quotient-based extended Euclid.
    // Even modulus or gcd(a,p) != 1 is an error with result 0.
    task automatic refModel(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] p, output logic expErr, output logic [W-1:0] expRes);
        logic signed [129:0] r0, r1, t0, t1, q, tmp;
        logic [127:0] prod;
        logic [W-1:0] inv, bb;
        r0 = $signed({66'd0, p});
        r1 = $signed({66'd0, a});
        t0 = '0;
        t1 = 130'sd1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        if (!p[0] || r0 != 130'sd1) begin
            expErr = 1'b1;
            expRes = '0;
        end else begin
            if (t0 < 0) t0 = t0 + $signed({66'd0, p});
            inv    = t0[W-1:0];
            bb     = m ? b : 64'd1;
            prod   = ({64'd0, bb} * {64'd0, inv}) % {64'd0, p};
            expErr = 1'b0;
            expRes = prod[W-1:0];
        end
    endtask

    // Presents one request at a negedge and drops start one cycle later.
    task automatic applyStimulus(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] p);
        @(negedge clk);
        bus.mode  = m;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.p_in  = p;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; lat counts edges from
    // the accept to the one that raised done. Bounded by MAXCYC.
    task automatic waitDone(output int lat, output logic tmo, output int readyHi);
        lat = 1; tmo = 1'b0; readyHi = 0;
        while (!bus.done) begin
            if (bus.ready) readyHi++;
            if (lat >= MAXCYC) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.state_o !== 3'(IDLE)) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", bus.state_o, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_inverse();
        int lat, rh; logic tmo;
        applyStimulus(MODE_INV, 64'd3, 64'd0, 64'd7);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL inv_busy got=%b exp=1", bus.busy); end
        waitDone(lat, tmo, rh);
        checks++; if (tmo) begin errors++; $display("[TB] FAIL inv_timeout got=%0d cycles exp=<%0d", lat, MAXCYC); end
        checks++; if (rh != 0) begin errors++; $display("[TB] FAIL inv_ready_low got=%0d ready cycles exp=0", rh); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL inv_err got=%b exp=0", bus.err); end
        checks++; if (bus.result !== 64'd5) begin errors++; $display("[TB] FAIL inv_result got=%h exp=5", bus.result); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL inv_done_width got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 64'd5) begin errors++; $display("[TB] FAIL inv_result_hold got=%h exp=5", bus.result); end
    endtask

    task automatic test_division();
        int lat, rh; logic tmo;
        applyStimulus(MODE_DIV, 64'd3, 64'd4, 64'd7);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.result !== 64'd6) begin errors++; $display("[TB] FAIL div_result got=%h exp=6 tmo=%b", bus.result, tmo); end
        applyStimulus(MODE_INV, 64'd2, 64'd77, 64'hFFFF_FFFB);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.result !== 64'h7FFF_FFFE) begin errors++; $display("[TB] FAIL inv2_result got=%h exp=7ffffffe tmo=%b", bus.result, tmo); end
    endtask

    task automatic test_latency();
        int lat, rh; logic tmo;
        applyStimulus(MODE_DIV, 64'd1, 64'd9, 64'd11);
        waitDone(lat, tmo, rh);
        checks++; if (bus.result !== 64'd9) begin errors++; $display("[TB] FAIL a1_result got=%h exp=9", bus.result); end
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL a1_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_errors();
        int lat, rh; logic tmo;
        applyStimulus(MODE_INV, 64'd3, 64'd0, 64'd9);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.err !== 1'b1) begin errors++; $display("[TB] FAIL gcd_err got=%b exp=1 tmo=%b", bus.err, tmo); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL gcd_result got=%h exp=0", bus.result); end
        applyStimulus(MODE_INV, 64'd3, 64'd0, 64'd8);
        waitDone(lat, tmo, rh);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL even_err got=%b exp=1", bus.err); end
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL even_latency got=%0d exp=3", lat); end
        applyStimulus(MODE_DIV, 64'd0, 64'd5, 64'd7);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.err !== 1'b1 || bus.result !== 64'd0) begin errors++; $display("[TB] FAIL zero_err got=%b/%h exp=1/0", bus.err, bus.result); end
    endtask

    task automatic test_back_to_back();
        int lat, rh; logic tmo;
        logic expErr; logic [W-1:0] expRes;
        logic [W-1:0] a1 = 64'h1234_5678_9ABC_DEF1;
        logic [W-1:0] p1 = 64'hFFFF_FFFF_FFFF_FFC5;
        refModel(MODE_INV, a1, 64'd0, p1, expErr, expRes);
        applyStimulus(MODE_INV, a1, 64'd0, p1);
        repeat (4) @(negedge clk);
        applyStimulus(MODE_DIV, 64'd3, 64'd4, 64'd7);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.result !== expRes || bus.err !== expErr) begin errors++; $display("[TB] FAIL busy_ignore got=%h exp=%h", bus.result, expRes); end
        bus.mode = MODE_DIV; bus.a_in = 64'd3; bus.b_in = 64'd4; bus.p_in = 64'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept got=%b exp=0", bus.ready); end
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.result !== 64'd6) begin errors++; $display("[TB] FAIL b2b_result got=%h exp=6", bus.result); end
    endtask

    task automatic test_reset_mid();
        int lat, rh, n; logic tmo;
        applyStimulus(MODE_INV, 64'd3, 64'd0, 64'd7);
        waitDone(lat, tmo, rh);
        applyStimulus(MODE_INV, 64'd5, 64'd0, 64'd13);
        n = 0;
        while (bus.state_o !== 3'(SUB) && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("[TB] FAIL reach_sub got=%0d exp=%0d", bus.state_o, SUB); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_hs got=%b%b exp=10", bus.ready, bus.done); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL midrst_result got=%h exp=0", bus.result); end
        rst = 1'b0;
        applyStimulus(MODE_INV, 64'd5, 64'd0, 64'd13);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || bus.result !== 64'd8 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL post_rst got=%h exp=8", bus.result); end
    endtask

    task automatic test_random();
        logic [W-1:0] primes [6] = '{64'hFFFF_FFFF_FFFF_FFC5, 64'h7FFF_FFFF_FFFF_FFE7,
                                    64'h3FFF_FFFF_FFFF_FFC7, 64'h1FFF_FFFF_FFFF_FFFF,
                                    64'd1000000007, 64'd13};
        int lat, rh; logic tmo;
        logic expErr; logic [W-1:0] expRes, a, b, p;
        logic m;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 4) begin
                logic [W-1:0] k;
                k = 64'($urandom_range(1, 32'h1FFF_FFFF)) * 2 + 1;
                p = 3 * k;
                a = 3 * 64'($urandom_range(1, 32'(k - 1)));
            end else begin
                p = primes[$urandom_range(0, 5)];
                a = {$urandom, $urandom} % (p - 1) + 1;
            end
            b = {$urandom, $urandom} % p;
            m = 1'($urandom_range(0, 1));
            refModel(m, a, b, p, expErr, expRes);
            applyStimulus(m, a, b, p);
            waitDone(lat, tmo, rh);
            checks++; if (tmo) begin errors++; $display("[TB] FAIL rand_timeout got=%0d exp=<%0d", lat, MAXCYC); end
            checks++; if (bus.err !== expErr) begin errors++; $display("[TB] FAIL rand_err a=%h p=%h got=%b exp=%b", a, p, bus.err, expErr); end
            checks++; if (bus.result !== expRes) begin errors++; $display("[TB] FAIL rand_result a=%h b=%h p=%h m=%b got=%h exp=%h", a, b, p, m, bus.result, expRes); end
        end
    endtask

`ifdef MDIV_WDOG_EN
    task automatic test_watchdog();
        int lat, rh; logic tmo;
        applyStimulus(MODE_INV, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 64'd15);
        waitDone(lat, tmo, rh);
        checks++; if (tmo || lat > 4 * W + 4 * W + 8) begin errors++; $display("[TB] FAIL wdog_bound got=%0d exp=<=%0d", lat, 8 * W + 8); end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.p_in  = '0;
        test_reset();
        test_inverse();
        test_division();
        test_latency();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MDIV_WDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
